io_buffer_arbiter: RTL and testbench

IO_BUFFER_ARBITER -- requirements
Module: io_buffer_arbiter

---
 rtl/io_buffer_arbiter.sv | 171 +++++++++++++++++
 tb/tb_io_buffer_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_buffer_arbiter.sv
// Shares one BRAM port between the host and the CGRA. The host owns the port while
// idle; a launch hands the port to the CGRA until the run finishes and a short drain ends.
module io_buffer_arbiter #(
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        Clk,
  input  logic        Resetn,

  input  logic        Host_Start,
  input  logic        Host_En,
  input  logic [3:0]  Host_Wen,
  input  logic [31:0] Host_Addr,
  input  logic [31:0] Host_Data_To_Bram,
  output logic [31:0] Host_Data_From_Bram,
  output logic        Host_Reject,

  input  logic        Cgra_En,
  input  logic [3:0]  Cgra_Wen,
  input  logic [31:0] Cgra_Addr,
  input  logic [31:0] Cgra_Data_To_Bram,
  output logic [31:0] Cgra_Data_From_Bram,

  output logic        Port_En,
  output logic [3:0]  Port_Wen,
  output logic [31:0] Port_Addr,
  output logic [31:0] Port_Data_To_Bram,
  input  logic [31:0] Port_Data_From_Bram,

  output logic        Computation_Start,
  input  logic        Computation_Done,

  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] Run_Cycles,
  output logic [1:0]  Dbg_State
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        reject_q, reject_d;

  logic [31:0] run_inc;
  logic        timeout_hit;
  logic        drain_last;
  logic        cgra_owner;

  // Saturating run counter; the timeout compares against the count this cycle will produce.
  assign run_inc     = (run_cycles_q == 32'hFFFF_FFFF) ? run_cycles_q : run_cycles_q + 32'd1;
  assign timeout_hit = TIMEOUT_EN && (run_inc == TIMEOUT_W);
  assign drain_last  = (drain_cnt_q == DRAIN_LAST);
  assign cgra_owner  = (state_q != ST_IDLE);

  // State register
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Host_Start) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (Computation_Done || timeout_hit) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status and counter next values
  always_comb begin
    run_cycles_d = run_cycles_q;
    drain_cnt_d  = drain_cnt_q;
    done_d       = done_q;
    error_d      = error_q;
    reject_d     = Host_En && cgra_owner;
    case (state_q)
      ST_IDLE: begin
        if (Host_Start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_START: begin
        run_cycles_d = '0;
      end
      ST_RUN: begin
        run_cycles_d = run_inc;
        if (Computation_Done || timeout_hit) begin
          drain_cnt_d = '0;
        end
        // A completion arriving on the timeout cycle counts as a clean finish.
        if (timeout_hit && !Computation_Done) begin
          error_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_last) begin
          done_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      default: begin
        run_cycles_d = run_cycles_q;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      drain_cnt_q  <= '0;
      run_cycles_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      drain_cnt_q  <= drain_cnt_d;
      run_cycles_q <= run_cycles_d;
      done_q       <= done_d;
      error_q      <= error_d;
      reject_q     <= reject_d;
    end
  end

  // Output logic: owner follows the state, so the port only changes hands on transitions.
  always_comb begin
    if (cgra_owner) begin
      Port_En           = Cgra_En;
      Port_Wen          = Cgra_Wen;
      Port_Addr         = Cgra_Addr;
      Port_Data_To_Bram = Cgra_Data_To_Bram;
    end else begin
      Port_En           = Host_En;
      Port_Wen          = Host_Wen;
      Port_Addr         = Host_Addr;
      Port_Data_To_Bram = Host_Data_To_Bram;
    end
    Computation_Start = (state_q == ST_START);
    Busy              = (state_q != ST_IDLE);
  end

  assign Host_Data_From_Bram = Port_Data_From_Bram;
  assign Cgra_Data_From_Bram = Port_Data_From_Bram;
  assign Host_Reject         = reject_q;
  assign Done                = done_q;
  assign Error               = error_q;
  assign Run_Cycles          = run_cycles_q;
  assign Dbg_State           = state_q;

endmodule

// File: tb/tb_io_buffer_arbiter.sv
// Directed bench for io_buffer_arbiter: three instances (no timeout, timeout 8, timeout 4)
// share one stimulus stream; each step checks the instance whose behaviour it targets.
module tb_io_buffer_arbiter;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        host_start;
  logic        host_en;
  logic [3:0]  host_wen;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        cgra_en;
  logic [3:0]  cgra_wen;
  logic [31:0] cgra_addr;
  logic [31:0] cgra_wdata;
  logic [31:0] port_rdata;
  logic        comp_done;

  logic [31:0] host_rdata [3];
  logic        host_reject [3];
  logic [31:0] cgra_rdata [3];
  logic        port_en [3];
  logic [3:0]  port_wen [3];
  logic [31:0] port_addr [3];
  logic [31:0] port_wdata [3];
  logic        comp_start [3];
  logic        busy [3];
  logic        done [3];
  logic        error [3];
  logic [31:0] run_cycles [3];
  logic [1:0]  st [3];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    io_buffer_arbiter #(
      .DRAIN_CYCLES  (2),
      .TIMEOUT_CYCLES((g == 0) ? 0 : ((g == 1) ? 8 : 4))
    ) u_dut (
      .Clk                (clk),
      .Resetn             (resetn),
      .Host_Start         (host_start),
      .Host_En            (host_en),
      .Host_Wen           (host_wen),
      .Host_Addr          (host_addr),
      .Host_Data_To_Bram  (host_wdata),
      .Host_Data_From_Bram(host_rdata[g]),
      .Host_Reject        (host_reject[g]),
      .Cgra_En            (cgra_en),
      .Cgra_Wen           (cgra_wen),
      .Cgra_Addr          (cgra_addr),
      .Cgra_Data_To_Bram  (cgra_wdata),
      .Cgra_Data_From_Bram(cgra_rdata[g]),
      .Port_En            (port_en[g]),
      .Port_Wen           (port_wen[g]),
      .Port_Addr          (port_addr[g]),
      .Port_Data_To_Bram  (port_wdata[g]),
      .Port_Data_From_Bram(port_rdata),
      .Computation_Start  (comp_start[g]),
      .Computation_Done   (comp_done),
      .Busy               (busy[g]),
      .Done               (done[g]),
      .Error              (error[g]),
      .Run_Cycles         (run_cycles[g]),
      .Dbg_State          (st[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn     = 1'b1;
    host_start = 1'b0;
    host_en    = 1'b0;
    host_wen   = 4'h0;
    host_addr  = 32'h0;
    host_wdata = 32'h0;
    cgra_en    = 1'b0;
    cgra_wen   = 4'h0;
    cgra_addr  = 32'h0;
    cgra_wdata = 32'h0;
    port_rdata = 32'h0;
    comp_done  = 1'b0;

    // Reset values, observed before any clock edge
    #2 resetn = 1'b0;
    #1;
    check("rst_state", 32'(st[0]), 32'(S_IDLE));
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_error", 32'(error[0]), 32'd0);
    check("rst_start", 32'(comp_start[0]), 32'd0);
    check("rst_reject", 32'(host_reject[0]), 32'd0);
    check("rst_run_cycles", run_cycles[0], 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("rel_no_start", 32'(comp_start[0]), 32'd0);

    // Host write in IDLE; CGRA request present but blocked
    host_en = 1'b1; host_wen = 4'hF; host_addr = 32'h10; host_wdata = 32'hDEADBEEF;
    cgra_en = 1'b1; cgra_wen = 4'h3; cgra_addr = 32'h99; cgra_wdata = 32'h0BAD_F00D;
    port_rdata = 32'h1234_5678;
    #1;
    check("idle_port_en", 32'(port_en[0]), 32'd1);
    check("idle_port_wen", 32'(port_wen[0]), 32'hF);
    check("idle_port_addr", port_addr[0], 32'h10);
    check("idle_port_data", port_wdata[0], 32'hDEADBEEF);
    check("host_rdata", host_rdata[0], 32'h1234_5678);
    check("cgra_rdata", cgra_rdata[0], 32'h1234_5678);
    tick();
    check("idle_no_reject", 32'(host_reject[0]), 32'd0);
    host_en = 1'b0; host_wen = 4'h0;
    #1;
    check("idle_cgra_blocked_en", 32'(port_en[0]), 32'd0);
    check("idle_cgra_blocked_wen", 32'(port_wen[0]), 32'd0);

    // Launch: START for one cycle, then RUN with the CGRA owning the port
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    check("start_state", 32'(st[0]), 32'(S_START));
    check("start_pulse", 32'(comp_start[0]), 32'd1);
    check("start_busy", 32'(busy[0]), 32'd1);
    check("start_port_en", 32'(port_en[0]), 32'd1);
    check("start_port_addr", port_addr[0], 32'h99);
    tick();
    check("run1_state", 32'(st[0]), 32'(S_RUN));
    check("run1_no_pulse", 32'(comp_start[0]), 32'd0);

    // Host access and a second Host_Start during RUN
    host_en = 1'b1; host_wen = 4'hF; host_start = 1'b1;
    cgra_en = 1'b0; cgra_wen = 4'h3;
    #1;
    check("run_port_en_cgra", 32'(port_en[0]), 32'd0);
    check("run_port_wen_cgra", 32'(port_wen[0]), 32'h3);
    tick();
    check("run_reject_pulse", 32'(host_reject[0]), 32'd1);
    check("run_restart_ignored", 32'(comp_start[0]), 32'd0);
    check("run_still_run", 32'(st[0]), 32'(S_RUN));
    host_en = 1'b0; host_start = 1'b0;
    tick();
    check("run_reject_clear", 32'(host_reject[0]), 32'd0);
    repeat (7) tick();
    comp_done = 1'b1;
    tick();
    comp_done = 1'b0;
    check("drain1_state", 32'(st[0]), 32'(S_DRAIN));
    check("drain1_busy", 32'(busy[0]), 32'd1);
    check("drain1_run_cycles", run_cycles[0], 32'd10);
    tick();
    check("drain2_state", 32'(st[0]), 32'(S_DRAIN));
    check("drain2_done_low", 32'(done[0]), 32'd0);
    tick();
    check("end_state", 32'(st[0]), 32'(S_IDLE));
    check("end_busy", 32'(busy[0]), 32'd0);
    check("end_done", 32'(done[0]), 32'd1);
    check("end_error", 32'(error[0]), 32'd0);
    check("end_run_cycles", run_cycles[0], 32'd10);
    comp_done = 1'b1;
    tick();
    comp_done = 1'b0;
    check("idle_done_ignored", 32'(st[0]), 32'(S_IDLE));
    check("idle_done_sticky", 32'(done[0]), 32'd1);

    // Asynchronous reset in the middle of a run
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    tick();
    host_en = 1'b1; host_wen = 4'h5; host_addr = 32'h44;
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_state", 32'(st[0]), 32'(S_IDLE));
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_start", 32'(comp_start[0]), 32'd0);
    check("mid_rst_done", 32'(done[0]), 32'd0);
    check("mid_rst_error", 32'(error[0]), 32'd0);
    check("mid_rst_reject", 32'(host_reject[0]), 32'd0);
    check("mid_rst_run_cycles", run_cycles[0], 32'd0);
    check("mid_rst_host_owns_wen", 32'(port_wen[0]), 32'h5);
    check("mid_rst_host_owns_addr", port_addr[0], 32'h44);
    tick();
    resetn = 1'b1; host_en = 1'b0; host_wen = 4'h0;
    tick();
    check("post_rst_no_start", 32'(comp_start[0]), 32'd0);
    check("post_rst_state", 32'(st[0]), 32'(S_IDLE));

    // Timeout runs: instance 1 after 8 RUN cycles, instance 2 after 4; instance 0 keeps running
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    repeat (7) tick();
    check("to8_run8_state", 32'(st[1]), 32'(S_RUN));
    check("to8_run8_error", 32'(error[1]), 32'd0);
    tick();
    check("to8_drain_state", 32'(st[1]), 32'(S_DRAIN));
    check("to8_drain_error", 32'(error[1]), 32'd1);
    check("to8_run_cycles", run_cycles[1], 32'd8);
    check("to4_idle_state", 32'(st[2]), 32'(S_IDLE));
    check("to4_error", 32'(error[2]), 32'd1);
    check("to4_done", 32'(done[2]), 32'd1);
    check("to4_run_cycles", run_cycles[2], 32'd4);
    check("to0_still_run", 32'(st[0]), 32'(S_RUN));
    check("to0_run_cycles", run_cycles[0], 32'd8);
    tick();
    tick();
    check("to8_end_state", 32'(st[1]), 32'(S_IDLE));
    check("to8_end_done", 32'(done[1]), 32'd1);
    check("to8_end_error", 32'(error[1]), 32'd1);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    check("to8_restart_state", 32'(st[1]), 32'(S_START));
    check("to8_restart_pulse", 32'(comp_start[1]), 32'd1);
    check("to8_restart_error_clr", 32'(error[1]), 32'd0);
    check("to8_restart_done_clr", 32'(done[1]), 32'd0);
    check("to0_start_ignored", 32'(comp_start[0]), 32'd0);
    check("to0_state_unchanged", 32'(st[0]), 32'(S_RUN));

    // Completion on the same cycle as the timeout (instance 2)
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    repeat (4) tick();
    comp_done = 1'b1;
    tick();
    comp_done = 1'b0;
    check("tie_drain_state", 32'(st[2]), 32'(S_DRAIN));
    check("tie_drain_error", 32'(error[2]), 32'd0);
    check("tie_run_cycles", run_cycles[2], 32'd4);
    tick();
    tick();
    check("tie_end_state", 32'(st[2]), 32'(S_IDLE));
    check("tie_end_done", 32'(done[2]), 32'd1);
    check("tie_end_error", 32'(error[2]), 32'd0);
    check("tie_end_busy", 32'(busy[2]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
